// File: rtl/ebi_frame_link_if.sv
// Handshake and pad bundle between the EBI bridge FSMs and ebi_frame_link.
// The slave view is the link itself; the master view is the bridge/pad side.
interface ebi_frame_link_if #(
  parameter int EBI_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter int LEN_WIDTH    = 6,
  parameter int MAX_BEATS    = 32
);
  logic                           bus_owner_i;
  logic                           tx_valid_i;
  logic                           tx_ready_o;
  logic [OPCODE_WIDTH-1:0]        tx_opcode_i;
  logic [LEN_WIDTH-1:0]           tx_len_i;
  logic [MAX_BEATS*EBI_WIDTH-1:0] tx_data_i;
  logic                           tx_busy_o;
  logic                           tx_done_o;
  logic                           rx_valid_o;
  logic                           rx_ready_i;
  logic [OPCODE_WIDTH-1:0]        rx_opcode_o;
  logic [LEN_WIDTH-1:0]           rx_len_o;
  logic [MAX_BEATS*EBI_WIDTH-1:0] rx_data_o;
  logic [1:0]                     rx_err_o;
  logic                           rx_overrun_o;
  logic [EBI_WIDTH-1:0]           ebi_i;
  logic [EBI_WIDTH-1:0]           ebi_o;
  logic [EBI_WIDTH-1:0]           ebi_oen;

  modport slave (
    input  bus_owner_i, tx_valid_i, tx_opcode_i, tx_len_i, tx_data_i, rx_ready_i, ebi_i,
    output tx_ready_o, tx_busy_o, tx_done_o, rx_valid_o, rx_opcode_o, rx_len_o,
           rx_data_o, rx_err_o, rx_overrun_o, ebi_o, ebi_oen
  );

  modport master (
    output bus_owner_i, tx_valid_i, tx_opcode_i, tx_len_i, tx_data_i, rx_ready_i, ebi_i,
    input  tx_ready_o, tx_busy_o, tx_done_o, rx_valid_o, rx_opcode_o, rx_len_o,
           rx_data_o, rx_err_o, rx_overrun_o, ebi_o, ebi_oen
  );
endinterface

// File: rtl/ebi_frame_link.sv
// Half-duplex EBI frame transceiver: start marker, header {len, opcode},
// payload beats and an XOR checksum beat, with tx/rx valid-ready handshakes.
//
// TX state | meaning
// TX_IDLE  | not driving; accepts a request when bus owner
// TX_START | driving START_PATTERN
// TX_HDR   | driving header {pad, len, opcode}
// TX_DATA  | driving payload beat tx_cnt
// TX_CSUM  | driving XOR checksum, tx_done_o pulse
//
// RX state | meaning
// RX_IDLE  | waiting for start marker
// RX_HDR   | sampling header, clearing buffer and running XOR
// RX_DATA  | storing payload beat rx_cnt
// RX_CSUM  | comparing checksum beat with running XOR
// RX_HOLD  | frame presented on rx_valid_o until rx_ready_i
module ebi_frame_link #(
  parameter int                   EBI_WIDTH     = 16,
  parameter int                   OPCODE_WIDTH  = 4,
  parameter int                   LEN_WIDTH     = 6,
  parameter int                   MAX_BEATS     = 32,
  parameter logic [EBI_WIDTH-1:0] START_PATTERN = {EBI_WIDTH{1'b1}}
) (
  input  logic           clk,
  input  logic           rstn,
  ebi_frame_link_if.slave bus
);

  localparam int                   DATA_W  = MAX_BEATS * EBI_WIDTH;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BEATS);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_HDR, TX_DATA, TX_CSUM} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_DATA, RX_CSUM, RX_HOLD} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic                    tx_ready, tx_accept, tx_last, tx_drive, tx_done;
  logic [LEN_WIDTH-1:0]    tx_len_sat, tx_len_q, tx_cnt;
  logic [OPCODE_WIDTH-1:0] tx_op_q;
  logic [DATA_W-1:0]       tx_data_q;
  logic [EBI_WIDTH-1:0]    tx_csum_q, tx_beat;

  logic                    rx_en, rx_is_start, rx_last, rx_oversize;
  logic [LEN_WIDTH-1:0]    rx_hdr_len, rx_len_q, rx_cnt;
  logic [OPCODE_WIDTH-1:0] rx_op_q;
  logic [DATA_W-1:0]       rx_data_q;
  logic [EBI_WIDTH-1:0]    rx_xor_q;
  logic [1:0]              rx_err_q;
  logic                    rx_overrun_q;

  // ---------------------------------------------------------------- TX
  assign tx_ready   = (tx_state == TX_IDLE) && bus.bus_owner_i;
  assign tx_accept  = bus.tx_valid_i && tx_ready;
  assign tx_len_sat = (bus.tx_len_i > MAX_LEN) ? MAX_LEN : bus.tx_len_i;
  assign tx_last    = (tx_cnt == tx_len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rstn) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_beat  = '0;
    tx_drive = 1'b1;
    tx_done  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_drive = 1'b0;
        if (tx_accept) tx_next = TX_START;
      end
      TX_START: begin
        tx_beat = START_PATTERN;
        tx_next = TX_HDR;
      end
      TX_HDR: begin
        tx_beat = EBI_WIDTH'({tx_len_q, tx_op_q});
        tx_next = (tx_len_q == '0) ? TX_CSUM : TX_DATA;
      end
      TX_DATA: begin
        tx_beat = tx_data_q[EBI_WIDTH-1:0];
        if (tx_last) tx_next = TX_CSUM;
      end
      TX_CSUM: begin
        tx_beat = tx_csum_q;
        tx_done = 1'b1;
        tx_next = TX_IDLE;
      end
      default: begin
        tx_drive = 1'b0;
        tx_next  = TX_IDLE;
      end
    endcase
  end

  // Payload shifts down one beat per cycle, so the low beat is always next out.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_op_q   <= '0;
      tx_len_q  <= '0;
      tx_cnt    <= '0;
      tx_data_q <= '0;
      tx_csum_q <= '0;
    end else if (tx_accept) begin
      tx_op_q   <= bus.tx_opcode_i;
      tx_len_q  <= tx_len_sat;
      tx_cnt    <= '0;
      tx_data_q <= bus.tx_data_i;
      tx_csum_q <= EBI_WIDTH'({tx_len_sat, bus.tx_opcode_i});
    end else if (tx_state == TX_DATA) begin
      tx_cnt    <= tx_cnt + LEN_WIDTH'(1);
      tx_data_q <= tx_data_q >> EBI_WIDTH;
      tx_csum_q <= tx_csum_q ^ tx_data_q[EBI_WIDTH-1:0];
    end
  end

  assign bus.tx_ready_o = tx_ready;
  assign bus.tx_busy_o  = tx_drive;
  assign bus.tx_done_o  = tx_done;
  assign bus.ebi_o      = tx_beat;
  assign bus.ebi_oen    = {EBI_WIDTH{~tx_drive}};

  // ---------------------------------------------------------------- RX
  // Enable only gates frame start and overrun; a frame already in progress completes.
  assign rx_en       = !bus.bus_owner_i && (tx_state == TX_IDLE);
  assign rx_is_start = (bus.ebi_i == START_PATTERN);
  assign rx_hdr_len  = bus.ebi_i[OPCODE_WIDTH +: LEN_WIDTH];
  assign rx_oversize = (rx_hdr_len > MAX_LEN);
  assign rx_last     = (rx_cnt == rx_len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rstn) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: if (rx_en && rx_is_start) rx_next = RX_HDR;
      RX_HDR: begin
        if (rx_oversize)             rx_next = RX_HOLD;
        else if (rx_hdr_len == '0)   rx_next = RX_CSUM;
        else                         rx_next = RX_DATA;
      end
      RX_DATA: if (rx_last) rx_next = RX_CSUM;
      RX_CSUM: rx_next = RX_HOLD;
      RX_HOLD: if (bus.rx_ready_i) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_op_q      <= '0;
      rx_len_q     <= '0;
      rx_cnt       <= '0;
      rx_data_q    <= '0;
      rx_xor_q     <= '0;
      rx_err_q     <= 2'b00;
      rx_overrun_q <= 1'b0;
    end else begin
      case (rx_state)
        RX_HDR: begin
          rx_op_q   <= bus.ebi_i[OPCODE_WIDTH-1:0];
          rx_len_q  <= rx_hdr_len;
          rx_cnt    <= '0;
          rx_data_q <= '0;
          rx_xor_q  <= bus.ebi_i;
          rx_err_q  <= rx_oversize ? 2'b10 : 2'b00;
        end
        RX_DATA: begin
          for (int i = 0; i < MAX_BEATS; i++) begin
            if (rx_cnt == LEN_WIDTH'(i)) rx_data_q[i*EBI_WIDTH +: EBI_WIDTH] <= bus.ebi_i;
          end
          rx_cnt   <= rx_cnt + LEN_WIDTH'(1);
          rx_xor_q <= rx_xor_q ^ bus.ebi_i;
        end
        RX_CSUM: if (bus.ebi_i != rx_xor_q) rx_err_q <= 2'b01;
        RX_HOLD: if (rx_en && rx_is_start) rx_overrun_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rx_valid_o   = (rx_state == RX_HOLD);
  assign bus.rx_opcode_o  = rx_op_q;
  assign bus.rx_len_o     = rx_len_q;
  assign bus.rx_data_o    = rx_data_q;
  assign bus.rx_err_o     = rx_err_q;
  assign bus.rx_overrun_o = rx_overrun_q;

endmodule

// File: tb/tb_ebi_frame_link.sv
// Bench for ebi_frame_link: frame-level queue model checked every cycle,
// directed literal cases, then randomized tx/rx traffic.
module tb_ebi_frame_link;
  localparam int EW = 16;
  localparam int OW = 4;
  localparam int LW = 6;
  localparam int MB = 32;
  localparam int DW = MB * EW;
  localparam logic [EW-1:0] START = {EW{1'b1}};

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ebi_frame_link_if #(.EBI_WIDTH(EW), .OPCODE_WIDTH(OW), .LEN_WIDTH(LW), .MAX_BEATS(MB)) bus ();

  ebi_frame_link #(.EBI_WIDTH(EW), .OPCODE_WIDTH(OW), .LEN_WIDTH(LW), .MAX_BEATS(MB),
                   .START_PATTERN(START)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // model state: expected tx beats still to be driven, and the rx frame view
  logic [EW-1:0] tx_q[$];
  logic [EW-1:0] rx_buf[$];
  logic [EW-1:0] bus_q[$];
  bit            m_col, m_valid, m_ovr;
  logic [OW-1:0] m_op;
  logic [LW-1:0] m_len;
  logic [DW-1:0] m_data;
  logic [1:0]    m_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void tx_push(input logic [OW-1:0] op, input logic [LW-1:0] len_in,
                                  input logic [DW-1:0] d);
    int n;
    logic [EW-1:0] hdr, x;
    n = (int'(len_in) > MB) ? MB : int'(len_in);
    hdr = '0;
    hdr[OW-1:0]   = op;
    hdr[OW +: LW] = LW'(n);
    tx_q.push_back(START);
    tx_q.push_back(hdr);
    x = hdr;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(d[i*EW +: EW]);
      x ^= d[i*EW +: EW];
    end
    tx_q.push_back(x);
  endfunction

  // Evaluate the collected beats once the header says the frame is complete.
  function automatic void rx_try_finish();
    int n;
    logic [EW-1:0] x;
    n = int'(rx_buf[0][OW +: LW]);
    m_op  = rx_buf[0][OW-1:0];
    m_len = rx_buf[0][OW +: LW];
    if (n > MB) begin
      m_data = '0; m_err = 2'b10; m_valid = 1'b1; m_col = 1'b0;
    end else if (rx_buf.size() == n + 2) begin
      x = '0;
      m_data = '0;
      for (int i = 0; i <= n; i++) x ^= rx_buf[i];
      for (int i = 0; i < n; i++) m_data[i*EW +: EW] = rx_buf[i+1];
      m_err = (rx_buf[n+1] == x) ? 2'b00 : 2'b01;
      m_valid = 1'b1; m_col = 1'b0;
    end
  endfunction

  initial forever begin
    bit rx_en, accept;
    @(posedge clk);
    if (!rstn) begin
      tx_q.delete(); rx_buf.delete();
      m_col = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_data = '0; m_err = 2'b00;
    end else begin
      rx_en  = !bus.bus_owner_i && (tx_q.size() == 0);
      accept = bus.tx_valid_i && bus.bus_owner_i && (tx_q.size() == 0);
      if (m_valid) begin
        if (rx_en && bus.ebi_i == START) m_ovr = 1'b1;
        if (bus.rx_ready_i) m_valid = 1'b0;
      end else if (m_col) begin
        rx_buf.push_back(bus.ebi_i);
        rx_try_finish();
      end else if (rx_en && bus.ebi_i == START) begin
        m_col = 1'b1;
        rx_buf.delete();
      end
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      if (accept) tx_push(bus.tx_opcode_i, bus.tx_len_i, bus.tx_data_i);
    end
  end

  initial forever begin
    logic [EW-1:0] e_o, e_oen;
    @(negedge clk);
    if (chk_on) begin
      e_o   = (tx_q.size() != 0) ? tx_q[0] : '0;
      e_oen = (tx_q.size() != 0) ? '0 : {EW{1'b1}};
      check("tx_ready", DW'(bus.tx_ready_o), DW'((tx_q.size() == 0) && bus.bus_owner_i));
      check("tx_busy",  DW'(bus.tx_busy_o),  DW'(tx_q.size() != 0));
      check("tx_done",  DW'(bus.tx_done_o),  DW'(tx_q.size() == 1));
      check("ebi_o",    DW'(bus.ebi_o),      DW'(e_o));
      check("ebi_oen",  DW'(bus.ebi_oen),    DW'(e_oen));
      check("rx_valid", DW'(bus.rx_valid_o), DW'(m_valid));
      check("rx_overrun", DW'(bus.rx_overrun_o), DW'(m_ovr));
      if (m_valid) begin
        check("rx_opcode", DW'(bus.rx_opcode_o), DW'(m_op));
        check("rx_len",    DW'(bus.rx_len_o),    DW'(m_len));
        check("rx_err",    DW'(bus.rx_err_o),    DW'(m_err));
        check("rx_data",   bus.rx_data_o,        m_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bus_q.size() != 0) bus.ebi_i = bus_q.pop_front();
    else                   bus.ebi_i = '0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.rx_valid_o && n < 40) begin
      step();
      n++;
    end
    check(name, DW'(bus.rx_valid_o), DW'(1'b1));
  endtask

  task automatic handoff();
    bus.rx_ready_i = 1'b1;
    step();
    bus.rx_ready_i = 1'b0;
  endtask

  task automatic push_frame_a(input logic [EW-1:0] csum);
    bus_q.push_back(START); bus_q.push_back(16'h0023);
    bus_q.push_back(16'hAAAA); bus_q.push_back(16'h5555); bus_q.push_back(csum);
  endtask

  task automatic push_rand_frame();
    logic [EW-1:0] hdr, x, w;
    int n;
    n = $urandom_range(0, MB + 3);
    hdr = '0;
    hdr[OW-1:0]   = OW'($urandom);
    hdr[OW +: LW] = LW'(n);
    bus_q.push_back(START);
    bus_q.push_back(hdr);
    if (n <= MB) begin
      x = hdr;
      for (int i = 0; i < n; i++) begin
        w = EW'($urandom);
        bus_q.push_back(w);
        x ^= w;
      end
      if ($urandom_range(0, 4) == 0) bus_q.push_back(EW'($urandom));
      else                           bus_q.push_back(x);
    end
  endtask

  initial begin
    logic [EW-1:0] exp7 [7];
    logic [EW-1:0] exp3 [3];
    exp7 = '{16'hFFFF, 16'h0047, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0043};
    exp3 = '{16'hFFFF, 16'h000F, 16'h000F};

    bus.bus_owner_i = 1'b0; bus.tx_valid_i = 1'b0; bus.tx_opcode_i = '0;
    bus.tx_len_i = '0; bus.tx_data_i = '0; bus.rx_ready_i = 1'b0; bus.ebi_i = '0;
    rstn = 1'b0;
    step(); chk_on = 1'b1;
    step(); step();
    rstn = 1'b1;
    check("rst_oen",     DW'(bus.ebi_oen), DW'(16'hFFFF));
    check("rst_ebi_o",   DW'(bus.ebi_o), DW'(16'h0000));
    check("rst_ready",   DW'(bus.tx_ready_o), DW'(1'b0));
    check("rst_rx_data", bus.rx_data_o, '0);
    check("rst_rx_err",  DW'(bus.rx_err_o), DW'(2'b00));
    check("rst_valid",   DW'(bus.rx_valid_o), DW'(1'b0));
    bus.bus_owner_i = 1'b1;
    step();
    check("ready_owner", DW'(bus.tx_ready_o), DW'(1'b1));

    // tx op 7, len 4, beats 1..4
    bus.tx_valid_i = 1'b1; bus.tx_opcode_i = 4'h7; bus.tx_len_i = 6'd4; bus.tx_data_i = '0;
    for (int i = 0; i < 4; i++) bus.tx_data_i[i*EW +: EW] = EW'(i + 1);
    step();
    bus.tx_valid_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("tx7_beat", DW'(bus.ebi_o), DW'(exp7[k]));
      check("tx7_oen",  DW'(bus.ebi_oen), DW'(16'h0000));
      check("tx7_done", DW'(bus.tx_done_o), DW'(k == 6));
      step();
    end
    check("tx7_ready_back", DW'(bus.tx_ready_o), DW'(1'b1));

    // tx op F, len 0
    bus.tx_valid_i = 1'b1; bus.tx_opcode_i = 4'hF; bus.tx_len_i = 6'd0;
    step();
    bus.tx_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("tx0_beat", DW'(bus.ebi_o), DW'(exp3[k]));
      step();
    end
    check("tx0_ready_back", DW'(bus.tx_ready_o), DW'(1'b1));

    // rx good frame, held 5 cycles
    bus.bus_owner_i = 1'b0;
    step();
    push_frame_a(16'hFFDC);
    wait_valid("rx_a_valid");
    for (int k = 0; k < 6; k++) begin
      check("rx_a_len",  DW'(bus.rx_len_o), DW'(6'd2));
      check("rx_a_op",   DW'(bus.rx_opcode_o), DW'(4'h3));
      check("rx_a_err",  DW'(bus.rx_err_o), DW'(2'b00));
      check("rx_a_data", bus.rx_data_o, DW'(32'h5555_AAAA));
      check("rx_a_hold", DW'(bus.rx_valid_o), DW'(1'b1));
      step();
    end
    handoff();
    check("rx_a_released", DW'(bus.rx_valid_o), DW'(1'b0));

    // bad checksum
    push_frame_a(16'h0000);
    wait_valid("rx_bad_valid");
    check("rx_bad_err", DW'(bus.rx_err_o), DW'(2'b01));
    handoff();

    // oversized length: valid the cycle after the header sample
    bus_q.push_back(START); bus_q.push_back(16'h03F3);
    step(); step();
    check("rx_big_not_yet", DW'(bus.rx_valid_o), DW'(1'b0));
    step();
    check("rx_big_valid", DW'(bus.rx_valid_o), DW'(1'b1));
    check("rx_big_err",   DW'(bus.rx_err_o), DW'(2'b10));
    check("rx_big_data",  bus.rx_data_o, '0);
    handoff();

    // overrun
    push_frame_a(16'hFFDC);
    wait_valid("rx_ovr_valid");
    bus_q.push_back(START); bus_q.push_back(16'h0011);
    bus_q.push_back(16'h1234); bus_q.push_back(16'h1225);
    for (int k = 0; k < 6; k++) step();
    check("ovr_set",  DW'(bus.rx_overrun_o), DW'(1'b1));
    check("ovr_data", bus.rx_data_o, DW'(32'h5555_AAAA));
    handoff();
    step();
    check("ovr_sticky", DW'(bus.rx_overrun_o), DW'(1'b1));

    // reset in the middle of a len 8 frame
    bus.bus_owner_i = 1'b1;
    step();
    bus.tx_valid_i = 1'b1; bus.tx_opcode_i = 4'h2; bus.tx_len_i = 6'd8;
    for (int i = 0; i < MB; i++) bus.tx_data_i[i*EW +: EW] = EW'($urandom);
    step();
    bus.tx_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("abort_oen",  DW'(bus.ebi_oen), DW'(16'hFFFF));
    check("abort_busy", DW'(bus.tx_busy_o), DW'(1'b0));
    for (int k = 0; k < 8; k++) begin
      check("abort_no_done", DW'(bus.tx_done_o), DW'(1'b0));
      step();
    end

    // randomized traffic
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 59) == 0) bus.bus_owner_i = ~bus.bus_owner_i;
      bus.tx_valid_i  = ($urandom_range(0, 3) == 0);
      bus.tx_opcode_i = OW'($urandom);
      bus.tx_len_i    = LW'($urandom_range(0, 40));
      for (int i = 0; i < MB; i++) bus.tx_data_i[i*EW +: EW] = EW'($urandom);
      bus.rx_ready_i  = ($urandom_range(0, 2) == 0);
      if (bus_q.size() == 0 && !bus.bus_owner_i && $urandom_range(0, 5) == 0) push_rand_frame();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
